// File: rtl/mean_frame_packer_pkg.sv
// Shared definitions for the MEAN frame packer.
// Provides the frame word width, the default sync header word and the
// frame-emission state encoding used by mean_frame_packer.
package mean_frame_packer_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 16'hEB90;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4
  } state_t;

endpackage

// File: rtl/mean_frame_packer_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   CLK, RESET_n : clock, synchronous active-low reset (flushes contents)
//   push, din    : write strobe and data (ignored while full)
//   pop          : consume the head word (ignored while empty)
//   dout         : head word, valid whenever empty is low
//   level        : current occupancy, 0..DEPTH
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mean_frame_packer.sv
// Packs the averaged MEAN sample stream into fixed-length frames:
//   SYNC_WORD, sequence number, FRAME_LEN payload words, checksum.
// The checksum is the 16-bit wrapping sum of the sequence word and payload.
// Ports:
//   CLK, RESET_n          : clock, synchronous active-low reset
//   DATA_IN, DATA_VALID   : incoming sample and its write strobe
//   OUT_DATA, OUT_VALID   : registered frame word and its valid flag
//   OUT_READY             : downstream accept (word taken on VALID & READY)
//   OUT_LAST              : marks the checksum word
//   OVERFLOW              : sticky, a sample was dropped on a full FIFO
//   FIFO_LEVEL            : current sample buffer occupancy
//
// state | meaning
// IDLE  | waiting for FRAME_LEN buffered samples
// HDR   | sync word presented
// SEQ   | sequence number presented
// PAY   | payload word presented
// CSUM  | checksum presented with OUT_LAST
module mean_frame_packer
  import mean_frame_packer_pkg::*;
#(
  parameter int                FRAME_LEN  = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [WORD_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic [WORD_W-1:0]             DATA_IN,
  input  logic                          DATA_VALID,
  output logic [WORD_W-1:0]             OUT_DATA,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          OUT_LAST,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PCW = $clog2(FRAME_LEN + 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [WORD_W-1:0] seq_q, seq_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic [PCW-1:0]    pay_cnt_q, pay_cnt_d;
  logic              overflow_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_dout;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  logic              accept;
  logic              frame_ready;
  logic              last_pay;

  // Fullness comes from the registered level, so a write into a full FIFO
  // is dropped even if a payload pop happens on the same edge.
  assign fifo_push   = DATA_VALID & ~fifo_full;
  assign accept      = out_valid_q & OUT_READY;
  assign frame_ready = (fifo_level >= LW'(FRAME_LEN));
  assign last_pay    = (pay_cnt_q == PCW'(FRAME_LEN));

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (DATA_IN),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      seq_q       <= '0;
      csum_q      <= '0;
      pay_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      pay_cnt_q   <= pay_cnt_d;
      if (DATA_VALID && fifo_full) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_ready)         state_d = HDR;
      HDR:     if (accept)              state_d = SEQ;
      SEQ:     if (accept)              state_d = PAY;
      PAY:     if (accept && last_pay)  state_d = CSUM;
      CSUM:    if (accept)              state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // The checksum accumulates each word as it is loaded into the output
  // register, so by the time the last payload word is accepted csum_q
  // already holds the complete sum.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    pay_cnt_d   = pay_cnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_ready) begin
          out_data_d  = SYNC_WORD;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          csum_d      = '0;
        end
      end
      HDR: begin
        if (accept) begin
          out_data_d = seq_q;
          csum_d     = csum_q + seq_q;
        end
      end
      SEQ: begin
        if (accept) begin
          out_data_d = fifo_dout;
          fifo_pop   = ~fifo_empty;
          csum_d     = csum_q + fifo_dout;
          pay_cnt_d  = PCW'(1);
        end
      end
      PAY: begin
        if (accept) begin
          if (last_pay) begin
            out_data_d = csum_q;
            out_last_d = 1'b1;
          end else begin
            out_data_d = fifo_dout;
            fifo_pop   = ~fifo_empty;
            csum_d     = csum_q + fifo_dout;
            pay_cnt_d  = pay_cnt_q + PCW'(1);
          end
        end
      end
      CSUM: begin
        if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          seq_d       = seq_q + WORD_W'(1);
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  assign OUT_DATA   = out_data_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_LAST   = out_last_q;
  assign OVERFLOW   = overflow_q;
  assign FIFO_LEVEL = fifo_level;

endmodule

// File: tb/tb_mean_frame_packer.sv
module tb_mean_frame_packer;

  localparam int FL    = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET_n;
  logic [15:0]   DATA_IN;
  logic          DATA_VALID;
  logic [15:0]   OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          OUT_LAST;
  logic          OVERFLOW;
  logic [LW-1:0] FIFO_LEVEL;

  always #5 CLK = ~CLK;

  mean_frame_packer #(
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (DEPTH),
    .SYNC_WORD  (16'hEB90)
  ) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_LAST   (OUT_LAST),
    .OVERFLOW   (OVERFLOW),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sample queue, occupancy, current frame word list.
  logic [15:0] m_q[$];
  int          m_level;
  bit          m_busy;
  int          m_idx;
  bit          m_ovf;
  logic [15:0] m_seq;
  logic [15:0] m_frame [FL+3];

  // Observations of accepted DUT words.
  int          dut_idx;
  logic [15:0] last_seq;
  logic [15:0] last_csum;
  bit          saw_0018;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_level = 0;
    m_busy  = 1'b0;
    m_idx   = 0;
    m_ovf   = 1'b0;
    m_seq   = 16'h0000;
    dut_idx = 0;
  endtask

  // One clock cycle: check current outputs, apply inputs, advance model.
  task automatic step(input bit dv, input logic [15:0] din, input bit rdy, input bit rst_n);
    bit push_ok;
    bit pop;
    logic [15:0] sum;
    chk("valid", 32'(OUT_VALID), 32'(m_busy));
    if (m_busy) begin
      chk("data", 32'(OUT_DATA), 32'(m_frame[m_idx]));
      chk("last", 32'(OUT_LAST), 32'(m_idx == FL + 2));
    end
    chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
    chk("level", 32'(FIFO_LEVEL), 32'(m_level));

    if (OUT_VALID && rdy && rst_n) begin
      if (dut_idx == 1) last_seq = OUT_DATA;
      if (OUT_LAST) last_csum = OUT_DATA;
      if (OUT_DATA == 16'h0018) saw_0018 = 1'b1;
      dut_idx = OUT_LAST ? 0 : dut_idx + 1;
    end

    DATA_VALID = dv;
    DATA_IN    = din;
    OUT_READY  = rdy;
    RESET_n    = rst_n;

    if (!rst_n) begin
      model_reset();
    end else begin
      push_ok = dv && (m_level < DEPTH);
      if (dv && !push_ok) m_ovf = 1'b1;
      pop = 1'b0;
      if (!m_busy) begin
        if (m_level >= FL) begin
          m_frame[0] = 16'hEB90;
          m_frame[1] = m_seq;
          sum = m_seq;
          for (int i = 0; i < FL; i++) begin
            m_frame[2+i] = m_q.pop_front();
            sum = sum + m_frame[2+i];
          end
          m_frame[FL+2] = sum;
          m_busy = 1'b1;
          m_idx  = 0;
        end
      end else if (rdy) begin
        if (m_idx >= 1 && m_idx <= FL) pop = 1'b1;
        if (m_idx == FL + 2) begin
          m_busy = 1'b0;
          m_seq  = m_seq + 16'd1;
        end else begin
          m_idx++;
        end
      end
      if (push_ok) m_q.push_back(din);
      m_level = m_level + int'(push_ok) - int'(pop);
    end

    @(posedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    bit          dv;
    logic [15:0] din;
    bit          rdy;
    bit          exp_valid;
    logic [15:0] exp_data;
    bit          exp_last;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int guard;
    bit rdy_pat [4];
    RESET_n    = 1'b0;
    DATA_VALID = 1'b0;
    DATA_IN    = '0;
    OUT_READY  = 1'b0;
    saw_0018   = 1'b0;
    last_seq   = '0;
    last_csum  = '0;
    model_reset();
    @(negedge CLK);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Frame 0: four samples, ready held high; each row lists the outputs
    // visible during that cycle.
    tbl[0]  = '{1, 16'h0001, 1, 0, 16'h0000, 0};
    tbl[1]  = '{1, 16'h0002, 1, 0, 16'h0000, 0};
    tbl[2]  = '{1, 16'h0003, 1, 0, 16'h0000, 0};
    tbl[3]  = '{1, 16'h0004, 1, 0, 16'h0000, 0};
    tbl[4]  = '{0, 16'h0000, 1, 0, 16'h0000, 0};
    tbl[5]  = '{0, 16'h0000, 1, 1, 16'hEB90, 0};
    tbl[6]  = '{0, 16'h0000, 1, 1, 16'h0000, 0};
    tbl[7]  = '{0, 16'h0000, 1, 1, 16'h0001, 0};
    tbl[8]  = '{0, 16'h0000, 1, 1, 16'h0002, 0};
    tbl[9]  = '{0, 16'h0000, 1, 1, 16'h0003, 0};
    tbl[10] = '{0, 16'h0000, 1, 1, 16'h0004, 0};
    tbl[11] = '{0, 16'h0000, 1, 1, 16'h000A, 1};
    tbl[12] = '{0, 16'h0000, 1, 0, 16'h0000, 0};
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d valid", i), 32'(OUT_VALID), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d data", i), 32'(OUT_DATA), 32'(tbl[i].exp_data));
        chk($sformatf("tbl%0d last", i), 32'(OUT_LAST), 32'(tbl[i].exp_last));
      end
      step(tbl[i].dv, tbl[i].din, tbl[i].rdy, 1);
    end

    // Second frame: all-ones payload, checksum wraps.
    for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
    chk("wrap seq", 32'(last_seq), 32'h0001);
    chk("wrap csum", 32'(last_csum), 32'hFFFD);

    // Backpressure with ready pattern 1,0,0,1.
    rdy_pat = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) step(1, 16'h0001 + 16'(i), rdy_pat[i % 4], 1);
    for (int i = 4; i < 40; i++) step(0, 0, rdy_pat[i % 4], 1);
    chk("stall csum", 32'(last_csum), 32'h000C);

    // Overflow: nine writes with the sink stalled.
    for (int i = 0; i < 9; i++) step(1, 16'h0010 + 16'(i), 0, 1);
    chk("ovf level", 32'(FIFO_LEVEL), 32'd8);
    chk("ovf flag", 32'(OVERFLOW), 32'd1);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1);
    chk("ovf dropped", 32'(saw_0018), 32'd0);
    chk("ovf sticky", 32'(OVERFLOW), 32'd1);

    // Three samples only: no frame, then the fourth starts one.
    for (int i = 0; i < 3; i++) step(1, 16'h0100 + 16'(i), 1, 1);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 1);
    step(1, 16'h0103, 1, 1);
    chk("start delay", 32'(OUT_VALID), 32'd0);
    step(0, 0, 1, 1);
    chk("start hdr", 32'(OUT_VALID), 32'd1);

    // Reset while the second payload word of this frame (seq 5) is shown.
    guard = 0;
    while (!(m_busy && m_idx == 3) && guard < 50) begin
      step(0, 0, 1, 1);
      guard++;
    end
    chk("reach pay2 timeout", 32'(guard < 50), 32'd1);
    chk("pay2 seq", 32'(m_frame[1]), 32'h0005);
    step(0, 0, 1, 0);
    chk("rst valid", 32'(OUT_VALID), 32'd0);
    chk("rst level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst ovf", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 16'h0200 + 16'(i), 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1);
    chk("rst seq", 32'(last_seq), 32'h0000);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 4, 16'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 999) != 0);
    end
    for (int i = 0; i < 40; i++) step(0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mean_frame_packer.md
Name: mean_frame_packer

Overview:
Downstream consumer of the MEAN averaging stage. It takes the averaged 16-bit sample stream (one word per DATA_VALID pulse) and buffers it in a small FIFO. It emits fixed-length frames over a valid/ready stream toward the host/ionogram interface. Frame format: sync header, sequence number, FRAME_LEN payload words, 16-bit checksum.

Parameters:
FRAME_LEN, 8, payload words per frame; legal range 1..64.
FIFO_DEPTH, 16, sample buffer depth; power of 2; must be >= FRAME_LEN.
SYNC_WORD, 16'hEB90, first word of every frame.

Ports:
CLK  in  1  clock.
RESET_n  in  1  reset.
DATA_IN  in  16  averaged sample, two's complement; passed through unmodified.
DATA_VALID  in  1  DATA_IN write strobe, one sample per high cycle.
OUT_DATA  out  16  frame word.
OUT_VALID  out  1  OUT_DATA holds a valid word.
OUT_READY  in  1  downstream accepts the word when OUT_VALID & OUT_READY.
OUT_LAST  out  1  high with the checksum word.
OVERFLOW  out  1  sticky; a sample was dropped because the FIFO was full.
FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset RESET_n: synchronous, active-low; clock CLK (rising edge).
- Reset effects: OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, OVERFLOW=0, FIFO_LEVEL=0, sequence counter=0, FSM=IDLE. Reset mid-frame abandons the frame and flushes the FIFO; no partial frame resumes.
- FIFO writes:
  - A write occurs when DATA_VALID=1 and the FIFO is not full.
  - Fullness is judged on the registered level before any same-cycle pop. A write while full is dropped even if a pop occurs that cycle, and OVERFLOW sets.
  - Simultaneous push and pop when not full: level unchanged.
- FSM states: IDLE, HDR, SEQ, PAY, CSUM.
  - IDLE -> HDR on the edge where FIFO_LEVEL >= FRAME_LEN. That edge loads OUT_DATA=SYNC_WORD and sets OUT_VALID=1. Header is therefore visible one cycle after the write edge that brought the level to FRAME_LEN.
  - HDR -> SEQ on accept; load the sequence counter value.
  - SEQ -> PAY on accept; load the FIFO head and pop it.
  - PAY: on each accept, load the next FIFO word and pop it. After the FRAME_LEN-th payload word is accepted, go to CSUM and load the checksum with OUT_LAST=1.
  - CSUM -> IDLE on accept. Clear OUT_VALID and OUT_LAST, and increment the sequence counter (16-bit, wraps 0xFFFF->0x0000).
  - There is a minimum of one idle cycle between frames.
- Payload is never interrupted by FIFO underflow, because FRAME_LEN words are present before the header is issued.
- Output register behaviour:
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST hold stable.
  - OUT_VALID never drops without an accept, except on reset.
  - OUT_READY is ignored while OUT_VALID=0.
- Checksum: unsigned 16-bit sum modulo 2^16 of the sequence word and all payload words; the header is excluded. The accumulator clears on the IDLE->HDR transition.
- Samples arriving during frame emission are buffered; overflow rules apply.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HDR, SEQ, PAY, CSUM);
  - SYNC_WORD default constant;
  - frame word width constant (16).
- Sub-module sync_fifo:
  - parameterised width and depth;
  - first-word-fall-through read;
  - ports push, pop, din, dout, level, full, empty;
  - drop-on-full is the writer's responsibility in mean_frame_packer.
- Top holds the FSM, payload counter, sequence counter, checksum accumulator and output register.

Test Plan:
1. FRAME_LEN=4, FIFO_DEPTH=8, OUT_READY=1; write 0x0001,0x0002,0x0003,0x0004 -> words EB90,0000,0001,0002,0003,0004,000A on consecutive cycles; OUT_LAST only on 000A; header appears the cycle after the 4th write.
2. Same stimulus with OUT_READY toggling 1,0,0,1,... -> identical word sequence; OUT_DATA stable during every stall; no word duplicated or skipped.
3. Second frame with samples 0xFFFF x4 -> EB90,0001,FFFF x4, checksum FFFD (0x0001 + 4*0xFFFF mod 2^16).
4. OUT_READY=0; write 9 samples 0x0010..0x0018 -> FIFO_LEVEL=8, OVERFLOW=1 after the 9th write. Raising OUT_READY -> two frames with payloads 0010..0013 and 0014..0017; 0x0018 never appears; OVERFLOW stays 1.
5. Write 3 samples only -> OUT_VALID stays 0 for 100 cycles; a 4th write -> frame starts the next cycle.
6. RESET_n low for 1 cycle during the 2nd payload word of the frame carrying seq 0x0005 -> next cycle OUT_VALID=0, FIFO_LEVEL=0, OVERFLOW=0. The next full frame carries sequence 0x0000.
